booth_mul_sched: RTL and testbench

- Round-robin scheduler that shares one pipelined 32x32 signed Booth multiplier among NUM_REQ requesters.
- Accepts at most one operand pair per cycle and issues it into the multiplier.
- Tracks each in-flight operation's requester ID through a tag shift register matched to the multiplier latency, and returns each 64-bit product to its originator.
- Sits between the requesting engines and the two-stage Booth datapath (steps 0-15 / 16-31).

---
 rtl/booth_pkg.sv | 20 ++
 rtl/booth_mul_sched_if.sv | 25 ++
 rtl/booth_mul_sched_rr_arbiter.sv | 52 +++++
 rtl/booth_mul_sched.sv | 131 +++++++++++++
 tb/tb_booth_mul_sched.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/booth_pkg.sv
// Shared constants and the in-flight tag record for the Booth multiplier scheduler.
// Optional feature macro: BOOTH_SCHED_ZERO_BYPASS_EN (adds a zero bit to each tag).
package booth_pkg;

    localparam int NUM_REQ  = 4;                 // requesters sharing the multiplier (2..8)
    localparam int ID_W     = $clog2(NUM_REQ);   // requester ID width
    localparam int DATA_W   = 32;                // operand width
    localparam int PROD_W   = 2 * DATA_W;        // product width (64)
    localparam int PIPE_LAT = 2;                 // issue-to-product latency of the datapath

    // One entry of the tag shift register that shadows the multiplier pipeline.
    typedef struct packed {
        logic            valid;
        logic [ID_W-1:0] id;
`ifdef BOOTH_SCHED_ZERO_BYPASS_EN
        logic            zero;   // product is forced to 0, the multiplier was not used
`endif
    } tag_t;

endpackage

// File: rtl/booth_mul_sched_if.sv
// Requester-side bus of the Booth multiplier scheduler: packed operand requests
// in, tagged products out. Requesters use the master modport, the scheduler the slave.
interface booth_mul_sched_if #(
    parameter int NUM_REQ = booth_pkg::NUM_REQ,
    parameter int DATA_W  = booth_pkg::DATA_W,
    parameter int ID_W    = booth_pkg::ID_W
);
    logic [NUM_REQ-1:0]        req_valid_i;
    logic [NUM_REQ-1:0]        req_ready_o;
    logic [NUM_REQ*DATA_W-1:0] req_a_i;
    logic [NUM_REQ*DATA_W-1:0] req_b_i;
    logic                      rsp_valid_o;
    logic [ID_W-1:0]           rsp_id_o;
    logic [2*DATA_W-1:0]       rsp_product_o;

    modport master (
        output req_valid_i, req_a_i, req_b_i,
        input  req_ready_o, rsp_valid_o, rsp_id_o, rsp_product_o
    );

    modport slave (
        input  req_valid_i, req_a_i, req_b_i,
        output req_ready_o, rsp_valid_o, rsp_id_o, rsp_product_o
    );
endinterface

// File: rtl/booth_mul_sched_rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant searching upward from rr_ptr
// with wrap-around, plus the rr_ptr register that moves past the last winner.
// The grant depends only on the valids and rr_ptr, and is forced to 0 in reset.
module rr_arbiter #(
    parameter int N     = 4,
    parameter int PTR_W = $clog2(N)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     valid,
    output logic [N-1:0]     grant,
    output logic [PTR_W-1:0] grant_id,
    output logic             grant_any
);
    logic [PTR_W-1:0] rr_ptr_reg;
    logic [PTR_W-1:0] rr_ptr_next;

    // Find the first valid requester at or after rr_ptr, wrapping around.
    always_comb begin
        int   idx;
        logic found;
        idx      = 0;
        found    = 1'b0;
        grant_id = '0;
        for (int k = 0; k < N; k++) begin
            idx = (int'(rr_ptr_reg) + k) % N;
            if (!found && valid[idx]) begin
                found    = 1'b1;
                grant_id = PTR_W'(idx);
            end
        end
        grant_any = found && !rst;
        grant     = grant_any ? (N'(1) << grant_id) : '0;
    end

    // A grant is always a transfer (no backpressure), so the pointer advances on it.
    always_comb begin
        rr_ptr_next = rr_ptr_reg;
        if (grant_any) begin
            rr_ptr_next = (grant_id == PTR_W'(N - 1)) ? '0 : grant_id + PTR_W'(1);
        end
    end

    // Round-robin pointer register.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_reg <= '0;
        end else begin
            rr_ptr_reg <= rr_ptr_next;
        end
    end
endmodule

// File: rtl/booth_mul_sched.sv
// Round-robin scheduler sharing one pipelined signed Booth multiplier among
// NUM_REQ requesters. A tag shift register matched to PIPE_LAT carries each
// operation's requester ID so the product can be routed back to its originator.
// Optional feature macro: BOOTH_SCHED_ZERO_BYPASS_EN (zero operands skip the
// multiplier and return a forced 0 product with unchanged latency and order).
module booth_mul_sched
    import booth_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    booth_mul_sched_if.slave    req_if,
    output logic                mul_valid_o,
    output logic [DATA_W-1:0]   mul_a_o,
    output logic [DATA_W-1:0]   mul_b_o,
    input  logic [PROD_W-1:0]   mul_product_i,
    output logic [ID_W+1:0]     inflight_o
);
    logic [DATA_W-1:0] a_arr [NUM_REQ];
    logic [DATA_W-1:0] b_arr [NUM_REQ];
    logic [NUM_REQ-1:0] grant;
    logic [ID_W-1:0]    grant_id;
    logic               transfer;
    logic [DATA_W-1:0]  sel_a;
    logic [DATA_W-1:0]  sel_b;
`ifdef BOOTH_SCHED_ZERO_BYPASS_EN
    logic               is_zero;
`endif
    tag_t               tag_in;
    tag_t               tag_pipe_reg [PIPE_LAT];
    tag_t               tag_last;
    logic               rsp_valid;
    logic [PROD_W-1:0]  rsp_product;
    logic [ID_W+1:0]    inflight_reg;

    // Unpack the per-requester operand buses.
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
        assign a_arr[gi] = req_if.req_a_i[gi*DATA_W +: DATA_W];
        assign b_arr[gi] = req_if.req_b_i[gi*DATA_W +: DATA_W];
    end

    rr_arbiter #(.N(NUM_REQ), .PTR_W(ID_W)) u_arb (
        .clk       (clk),
        .rst       (rst),
        .valid     (req_if.req_valid_i),
        .grant     (grant),
        .grant_id  (grant_id),
        .grant_any (transfer)
    );

    assign req_if.req_ready_o = grant;
    assign sel_a = a_arr[grant_id];
    assign sel_b = b_arr[grant_id];

    // Issue the granted operands straight to the datapath; idle drives zeros.
    always_comb begin
        mul_valid_o = transfer;
        mul_a_o     = '0;
        mul_b_o     = '0;
`ifdef BOOTH_SCHED_ZERO_BYPASS_EN
        is_zero     = (sel_a == '0) || (sel_b == '0);
        mul_valid_o = transfer && !is_zero;
`endif
        if (mul_valid_o) begin
            mul_a_o = sel_a;
            mul_b_o = sel_b;
        end
    end

    // Tag entering the shadow pipe this cycle.
    always_comb begin
        tag_in       = '0;
        tag_in.valid = transfer;
        tag_in.id    = grant_id;
`ifdef BOOTH_SCHED_ZERO_BYPASS_EN
        tag_in.zero  = is_zero;
`endif
    end

    // First tag stage; reset drops every in-flight operation.
    always_ff @(posedge clk) begin
        if (rst) begin
            tag_pipe_reg[0] <= '0;
        end else begin
            tag_pipe_reg[0] <= tag_in;
        end
    end

    for (genvar gi = 1; gi < PIPE_LAT; gi++) begin : g_tag_stage
        // Remaining tag stages advance every cycle, in lockstep with the datapath.
        always_ff @(posedge clk) begin
            if (rst) begin
                tag_pipe_reg[gi] <= '0;
            end else begin
                tag_pipe_reg[gi] <= tag_pipe_reg[gi-1];
            end
        end
    end

    assign tag_last  = tag_pipe_reg[PIPE_LAT-1];
    assign rsp_valid = tag_last.valid && !rst;

    // Route the datapath product back only when a tagged operation completes.
    always_comb begin
        rsp_product = '0;
        if (rsp_valid) begin
            rsp_product = mul_product_i;
`ifdef BOOTH_SCHED_ZERO_BYPASS_EN
            if (tag_last.zero) begin
                rsp_product = '0;
            end
`endif
        end
    end

    assign req_if.rsp_valid_o   = rsp_valid;
    assign req_if.rsp_id_o      = rsp_valid ? tag_last.id : '0;
    assign req_if.rsp_product_o = rsp_product;

    // In-flight counter: +1 per transfer, -1 per response.
    always_ff @(posedge clk) begin
        if (rst) begin
            inflight_reg <= '0;
        end else if (transfer && !rsp_valid) begin
            inflight_reg <= inflight_reg + (ID_W+2)'(1);
        end else if (!transfer && rsp_valid) begin
            inflight_reg <= inflight_reg - (ID_W+2)'(1);
        end
    end

    assign inflight_o = inflight_reg;
endmodule

// File: tb/tb_booth_mul_sched.sv
// Self-checking bench for booth_mul_sched: table-driven single issues with
// hand-computed products, then directed contention, reset and random sequences.
module tb_booth_mul_sched;
    import booth_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    booth_mul_sched_if #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .ID_W(ID_W)) bus ();

    logic              mul_valid;
    logic [DATA_W-1:0] mul_a;
    logic [DATA_W-1:0] mul_b;
    logic [PROD_W-1:0] mul_product;
    logic [ID_W+1:0]   inflight;
    logic [PROD_W-1:0] p1;
    logic [PROD_W-1:0] p2;

    booth_mul_sched dut (
        .clk           (clk),
        .rst           (rst),
        .req_if        (bus),
        .mul_valid_o   (mul_valid),
        .mul_a_o       (mul_a),
        .mul_b_o       (mul_b),
        .mul_product_i (mul_product),
        .inflight_o    (inflight)
    );

    function automatic logic [63:0] smul(input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] x;
        logic signed [63:0] y;
        x = {{32{a[31]}}, a};
        y = {{32{b[31]}}, b};
        return x * y;
    endfunction

    // Two-stage multiplier model; junk when nothing was issued.
    always @(posedge clk) begin
        p1 <= mul_valid ? smul(mul_a, mul_b) : 64'hDEAD_BEEF_DEAD_BEEF;
        p2 <= p1;
    end
    assign mul_product = p2;

    int          errors = 0;
    int          checks = 0;
    logic [31:0] op_a [4];
    logic [31:0] op_b [4];
    logic        sv_v [2];
    int          sv_id [2];
    logic [63:0] sv_p [2];
    int          infl_m;
    int          ptr_m;

    typedef struct {
        int          req;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] prod;
    } vec_t;
    vec_t tbl [6];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int rr_pick(input logic [3:0] v);
        for (int k = 0; k < 4; k++) begin
            if (v[(ptr_m + k) % 4]) return (ptr_m + k) % 4;
        end
        return -1;
    endfunction

    // One clock cycle: drive inputs, check against the bench model, advance the model.
    task automatic cycle(input logic [3:0] v, input int g, input logic r);
        logic [3:0]  exp_ready;
        logic        exp_mv;
        logic        zero;
        int          gi;
        @(negedge clk);
        rst = r;
        bus.req_valid_i = v;
        for (int i = 0; i < 4; i++) begin
            bus.req_a_i[i*32 +: 32] = op_a[i];
            bus.req_b_i[i*32 +: 32] = op_b[i];
        end
        #2;
        if (r) begin
            chk("rst_ready", 64'(bus.req_ready_o), 64'(0));
            chk("rst_mul_valid", 64'(mul_valid), 64'(0));
            chk("rst_rsp_valid", 64'(bus.rsp_valid_o), 64'(0));
            sv_v[0] = 1'b0;
            sv_v[1] = 1'b0;
            infl_m  = 0;
            ptr_m   = 0;
            return;
        end
        gi        = (g < 0) ? 0 : g;
        exp_ready = (g < 0) ? 4'b0 : 4'(1 << g);
        zero      = (g >= 0) && (op_a[gi] == 0 || op_b[gi] == 0);
`ifdef BOOTH_SCHED_ZERO_BYPASS_EN
        exp_mv = (g >= 0) && !zero;
`else
        exp_mv = (g >= 0);
`endif
        chk("ready", 64'(bus.req_ready_o), 64'(exp_ready));
        chk("mul_valid", 64'(mul_valid), 64'(exp_mv));
        chk("mul_a", 64'(mul_a), 64'(exp_mv ? op_a[gi] : 32'd0));
        chk("mul_b", 64'(mul_b), 64'(exp_mv ? op_b[gi] : 32'd0));
        chk("rsp_valid", 64'(bus.rsp_valid_o), 64'(sv_v[1]));
        chk("rsp_product", bus.rsp_product_o, sv_v[1] ? sv_p[1] : 64'd0);
        if (sv_v[1]) begin
            chk("rsp_id", 64'(bus.rsp_id_o), 64'(sv_id[1]));
            $display("rsp id=%0d product=%h", bus.rsp_id_o, bus.rsp_product_o);
        end
        chk("inflight", 64'(inflight), 64'(infl_m));
        infl_m   = infl_m + ((g >= 0) ? 1 : 0) - (sv_v[1] ? 1 : 0);
        sv_v[1]  = sv_v[0];
        sv_id[1] = sv_id[0];
        sv_p[1]  = sv_p[0];
        sv_v[0]  = (g >= 0);
        sv_id[0] = gi;
        sv_p[0]  = (g >= 0) ? smul(op_a[gi], op_b[gi]) : 64'd0;
        if (g >= 0) ptr_m = (g + 1) % 4;
    endtask

    initial begin
        logic [3:0] v;
        tbl[0] = '{2, 32'd7,          32'hFFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB};
        tbl[1] = '{0, 32'h8000_0000,  32'h8000_0000, 64'h4000_0000_0000_0000};
        tbl[2] = '{3, 32'h7FFF_FFFF,  32'hFFFF_FFFF, 64'hFFFF_FFFF_8000_0001};
        tbl[3] = '{1, 32'd0,          32'd5,         64'h0};
        tbl[4] = '{1, 32'h0001_0000,  32'h0001_0000, 64'h0000_0001_0000_0000};
        tbl[5] = '{0, 32'd123,        32'd456,       64'h0000_0000_0000_DB18};

        bus.req_valid_i = '0;
        bus.req_a_i     = '0;
        bus.req_b_i     = '0;
        for (int i = 0; i < 4; i++) begin
            op_a[i] = '0;
            op_b[i] = '0;
        end
        sv_v[0] = 1'b0; sv_v[1] = 1'b0;
        sv_id[0] = 0;   sv_id[1] = 0;
        sv_p[0] = '0;   sv_p[1] = '0;
        infl_m = 0;
        ptr_m  = 0;

        // Reset with and without requests pending, then the idle reset state.
        cycle(4'h0, -1, 1'b1);
        cycle(4'hF, -1, 1'b1);
        cycle(4'h0, -1, 1'b0);

        // Single issues with hand-computed products.
        for (int i = 0; i < 6; i++) begin
            op_a[tbl[i].req] = tbl[i].a;
            op_b[tbl[i].req] = tbl[i].b;
            cycle(4'(1 << tbl[i].req), tbl[i].req, 1'b0);
            cycle(4'h0, -1, 1'b0);
            cycle(4'h0, -1, 1'b0);
            chk("vec_product", bus.rsp_product_o, tbl[i].prod);
            chk("vec_id", 64'(bus.rsp_id_o), 64'(tbl[i].req));
        end

        // One requester held valid is granted every cycle.
        op_a[1] = 32'd5; op_b[1] = 32'hFFFF_FFFA;
        for (int k = 0; k < 4; k++) cycle(4'b0010, 1, 1'b0);
        cycle(4'h0, -1, 1'b0);
        cycle(4'h0, -1, 1'b0);

        // Full contention after reset: strict rotation 0,1,2,3,...
        cycle(4'h0, -1, 1'b1);
        for (int i = 0; i < 4; i++) begin
            op_a[i] = 32'(i + 1);
            op_b[i] = 32'hFFFF_FFF0 - 32'(i);
        end
        for (int k = 0; k < 8; k++) cycle(4'hF, k % 4, 1'b0);
        cycle(4'h0, -1, 1'b0);
        cycle(4'h0, -1, 1'b0);

        // Reset one cycle after an issue: the op vanishes, requester 0 wins next.
        cycle(4'b0100, 2, 1'b0);
        cycle(4'hF, -1, 1'b1);
        cycle(4'hF, 0, 1'b0);
        for (int k = 0; k < 3; k++) cycle(4'h0, -1, 1'b0);

        // Zero operand mixed into a contended stream.
        op_a[1] = 32'd0; op_b[1] = 32'd5;
        for (int k = 0; k < 4; k++) cycle(4'hF, rr_pick(4'hF), 1'b0);
        cycle(4'h0, -1, 1'b0);
        cycle(4'h0, -1, 1'b0);

        // Sparse random traffic against the reference model.
        for (int k = 0; k < 60; k++) begin
            v = 4'($urandom_range(0, 15));
            for (int i = 0; i < 4; i++) begin
                op_a[i] = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
                op_b[i] = $urandom;
            end
            cycle(v, rr_pick(v), 1'b0);
        end
        for (int k = 0; k < 3; k++) cycle(4'h0, -1, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
